// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with bounded lock, sharing one single-beat
// addr/we/wdata/rdata bus in front of the peripheral Bridge.
module bus_arbiter #(
  parameter int unsigned LOCK_MAX  = 4,
  parameter logic [31:0] IDLE_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  gnt
);

  localparam int unsigned   CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rrPtr_q, rrPtr_d;
  logic [CW-1:0] lockCnt_q, lockCnt_d;
  logic          lockedGrant_q, lockedGrant_d;
  logic [31:0]   m0Rdata_q, m1Rdata_q;

  logic          ownerReq;
  logic          ownerLock;
  logic          ownerWe;
  logic [31:0]   ownerAddr;
  logic [31:0]   ownerWdata;
  logic          otherReq;
  logic          accessLive;
  logic          idleWinner;

  always_comb begin
    ownerReq   = owner_q ? m1_req   : m0_req;
    ownerLock  = owner_q ? m1_lock  : m0_lock;
    ownerWe    = owner_q ? m1_we    : m0_we;
    ownerAddr  = owner_q ? m1_addr  : m0_addr;
    ownerWdata = owner_q ? m1_wdata : m0_wdata;
    otherReq   = owner_q ? m0_req   : m1_req;
  end

  // A locked re-grant whose owner has no request pending is not a real access.
  assign accessLive = (state_q == ACCESS) && !(lockedGrant_q && !ownerReq);

  assign idleWinner = (m0_req && m1_req) ? rrPtr_q : m1_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      rrPtr_q       <= 1'b0;
      lockCnt_q     <= '0;
      lockedGrant_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rrPtr_q       <= rrPtr_d;
      lockCnt_q     <= lockCnt_d;
      lockedGrant_q <= lockedGrant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rrPtr_d       = rrPtr_q;
    lockCnt_d     = lockCnt_q;
    lockedGrant_d = lockedGrant_q;
    case (state_q)
      IDLE: begin
        lockCnt_d     = '0;
        lockedGrant_d = 1'b0;
        if (m0_req || m1_req) begin
          owner_d = idleWinner;
          rrPtr_d = ~idleWinner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (accessLive) begin
          state_d = RESP;
        end else begin
          state_d       = IDLE;
          lockCnt_d     = '0;
          lockedGrant_d = 1'b0;
        end
      end
      RESP: begin
        // The owner is being acked now, so only the other master competes
        // unless the owner holds a lock that has not yet run out.
        if (ownerLock && ((lockCnt_q < LOCK_LIM) || !otherReq)) begin
          state_d       = ACCESS;
          lockedGrant_d = 1'b1;
          if (otherReq) begin
            lockCnt_d = lockCnt_q + CW'(1);
          end
        end else if (otherReq) begin
          state_d       = ACCESS;
          owner_d       = ~owner_q;
          rrPtr_d       = owner_q;
          lockCnt_d     = '0;
          lockedGrant_d = 1'b0;
        end else begin
          state_d       = IDLE;
          lockCnt_d     = '0;
          lockedGrant_d = 1'b0;
        end
      end
      default: begin
        state_d       = IDLE;
        lockCnt_d     = '0;
        lockedGrant_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus_addr  = IDLE_DATA;
    bus_wdata = IDLE_DATA;
    bus_we    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    gnt       = 2'b00;
    if (accessLive) begin
      bus_addr  = ownerAddr;
      bus_wdata = ownerWdata;
      bus_we    = ownerWe;
    end
    if (state_q == RESP) begin
      m0_ack = ~owner_q;
      m1_ack = owner_q;
    end
    if (accessLive || (state_q == RESP)) begin
      gnt = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Read data is captured at the end of the access cycle and held until the
  // same master completes another transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m0Rdata_q <= '0;
      m1Rdata_q <= '0;
    end else if (accessLive) begin
      if (owner_q) begin
        m1Rdata_q <= bus_rdata;
      end else begin
        m0Rdata_q <= bus_rdata;
      end
    end
  end

  assign m0_rdata = m0Rdata_q;
  assign m1_rdata = m1Rdata_q;

endmodule
